// File: rtl/fir_seq_pkg.sv
// Shared types and defaults for the fir_sequencer slice.
package fir_seq_pkg;

  localparam int unsigned TAPS_DEF     = 16;
  localparam int unsigned DW_DEF       = 16;
  localparam int unsigned FIRE_LEN_DEF = 6;
  localparam int unsigned TIMEOUT_DEF  = 32;

  typedef enum logic [2:0] {
    IDLE,
    WIND,
    READY,
    LOAD,
    FIRE,
    WAIT
  } state_t;

  // Width of a counter holding 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_hist_buf.sv
// TAPS-deep sample history: hist[0] newest, hist[TAPS-1] oldest.
// Synchronous clear wins over shift; read port is combinational.
module fir_hist_buf
  import fir_seq_pkg::*;
#(
  parameter int unsigned TAPS = TAPS_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned IW   = cnt_w(TAPS)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          shift_en,
  input  logic [DW-1:0] din,
  input  logic [IW-1:0] rd_idx,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] hist_q [TAPS];
  logic [DW-1:0] hist_d [TAPS];

  // Next history: clear, shift in a new sample, or hold.
  always_comb begin
    hist_d = hist_q;
    if (clear) begin
      for (int unsigned i = 0; i < TAPS; i++) hist_d[i] = '0;
    end else if (shift_en) begin
      hist_d[0] = din;
      for (int unsigned i = 1; i < TAPS; i++) hist_d[i] = hist_q[i-1];
    end
  end

  // History storage.
  always_ff @(posedge clk) begin
    hist_q <= hist_d;
  end

  assign rd_data = hist_q[rd_idx];

endmodule

// File: rtl/fir_sequencer.sv
// Upstream driver for the fir stage: winds coefficients, keeps the sample
// history, replays it per sample, fires the filter and captures its result.
// Optional macro FIR_SEQ_TIMEOUT_EN adds a WAIT watchdog driving err.
module fir_sequencer
  import fir_seq_pkg::*;
#(
  parameter int unsigned TAPS     = TAPS_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned FIRE_LEN = FIRE_LEN_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_start,
  input  logic          coef_valid,
  input  logic [DW-1:0] coef_data,
  output logic          coef_ready,
  input  logic          smp_valid,
  input  logic [DW-1:0] smp_data,
  output logic          smp_ready,
  output logic          fir_wind,
  output logic          fir_load,
  output logic          fir_in_valid,
  output logic [DW-1:0] fir_data,
  input  logic          fir_out_valid,
  input  logic [DW-1:0] fir_out,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic          err
);

  localparam int unsigned CW = cnt_w(TAPS);
  localparam int unsigned FW = cnt_w(FIRE_LEN);

  if (TAPS < 2 || FIRE_LEN < 1 || TIMEOUT < 1) begin : g_cfg_check
    $error("fir_sequencer: TAPS must be >= 2, FIRE_LEN and TIMEOUT >= 1");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          coef_loaded_q, coef_loaded_d;
  logic          coef_ready_q, coef_ready_d;
  logic          smp_ready_q, smp_ready_d;
  logic          fir_wind_q, fir_wind_d;
  logic          fir_load_q, fir_load_d;
  logic          fir_in_valid_q, fir_in_valid_d;
  logic [DW-1:0] fir_data_q, fir_data_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;

`ifdef FIR_SEQ_TIMEOUT_EN
  localparam int unsigned TW = cnt_w(TIMEOUT);
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
`endif

  logic          shift_en;
  logic [CW-1:0] rd_idx;
  logic [DW-1:0] rd_data;

  fir_hist_buf #(
    .TAPS (TAPS),
    .DW   (DW),
    .IW   (CW)
  ) u_hist (
    .clk      (clk),
    .clear    (!rst),
    .shift_en (shift_en),
    .din      (smp_data),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data)
  );

  // Next state, counters and registered outputs.
  // Replay reads one entry ahead: the accept cycle reads hist[TAPS-2], which
  // becomes hist[TAPS-1] after the shift, so fir_data lines up with fir_load.
  always_comb begin
    state_d        = state_q;
    ccnt_d         = ccnt_q;
    lcnt_d         = lcnt_q;
    fcnt_d         = fcnt_q;
    coef_loaded_d  = coef_loaded_q;
    fir_wind_d     = 1'b0;
    fir_load_d     = 1'b0;
    fir_in_valid_d = 1'b0;
    fir_data_d     = '0;
    res_valid_d    = 1'b0;
    res_data_d     = res_data_q;
    shift_en       = 1'b0;
    rd_idx         = (state_q == LOAD) ? CW'(TAPS - 1) - lcnt_q : CW'(TAPS - 2);
`ifdef FIR_SEQ_TIMEOUT_EN
    wcnt_d         = '0;
    err_d          = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d       = WIND;
          coef_loaded_d = 1'b0;
        end
      end
      WIND: begin
        if (coef_valid && coef_ready_q) begin
          fir_wind_d = 1'b1;
          fir_data_d = coef_data;
          if (ccnt_q == CW'(TAPS - 1)) begin
            ccnt_d        = '0;
            coef_loaded_d = 1'b1;
            state_d       = READY;
          end else begin
            ccnt_d = ccnt_q + 1'b1;
          end
        end
      end
      READY: begin
        // A reconfiguration request wins; a coincident sample is not taken.
        if (cfg_start) begin
          state_d       = WIND;
          coef_loaded_d = 1'b0;
        end else if (smp_valid && smp_ready_q) begin
          shift_en   = 1'b1;
          fir_load_d = 1'b1;
          fir_data_d = rd_data;
          lcnt_d     = CW'(1);
          state_d    = LOAD;
        end
      end
      LOAD: begin
        fir_load_d = 1'b1;
        fir_data_d = rd_data;
        if (lcnt_q == CW'(TAPS - 1)) begin
          lcnt_d  = '0;
          state_d = FIRE;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      FIRE: begin
        fir_in_valid_d = 1'b1;
        if (fcnt_q == FW'(FIRE_LEN - 1)) begin
          fcnt_d  = '0;
          state_d = WAIT;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (fir_out_valid) begin
          res_data_d  = fir_out;
          res_valid_d = 1'b1;
          state_d     = READY;
        end
`ifdef FIR_SEQ_TIMEOUT_EN
        else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = READY;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    coef_ready_d = (state_d == WIND);
    smp_ready_d  = (state_d == READY) && coef_loaded_d;
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      ccnt_q         <= '0;
      lcnt_q         <= '0;
      fcnt_q         <= '0;
      coef_loaded_q  <= 1'b0;
      coef_ready_q   <= 1'b0;
      smp_ready_q    <= 1'b0;
      fir_wind_q     <= 1'b0;
      fir_load_q     <= 1'b0;
      fir_in_valid_q <= 1'b0;
      fir_data_q     <= '0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
`ifdef FIR_SEQ_TIMEOUT_EN
      wcnt_q         <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      ccnt_q         <= ccnt_d;
      lcnt_q         <= lcnt_d;
      fcnt_q         <= fcnt_d;
      coef_loaded_q  <= coef_loaded_d;
      coef_ready_q   <= coef_ready_d;
      smp_ready_q    <= smp_ready_d;
      fir_wind_q     <= fir_wind_d;
      fir_load_q     <= fir_load_d;
      fir_in_valid_q <= fir_in_valid_d;
      fir_data_q     <= fir_data_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
`ifdef FIR_SEQ_TIMEOUT_EN
      wcnt_q         <= wcnt_d;
      err_q          <= err_d;
`endif
    end
  end

  assign coef_ready   = coef_ready_q;
  assign smp_ready    = smp_ready_q;
  assign fir_wind     = fir_wind_q;
  assign fir_load     = fir_load_q;
  assign fir_in_valid = fir_in_valid_q;
  assign fir_data     = fir_data_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
`ifdef FIR_SEQ_TIMEOUT_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: table of ramp samples with closed-form sums,
// randomized samples against a queue-based history model, plus hand-written
// sequences for gaps, cfg/sample collision, mid-replay reset and watchdog.
module tb_fir_sequencer;

  localparam int unsigned TAPS     = 16;
  localparam int unsigned DW       = 16;
  localparam int unsigned FIRE_LEN = 6;
  localparam int unsigned TIMEOUT  = 32;
  localparam int unsigned FIR_LAT  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_start = 1'b0;
  logic          coef_valid = 1'b0;
  logic [DW-1:0] coef_data = '0;
  logic          coef_ready;
  logic          smp_valid = 1'b0;
  logic [DW-1:0] smp_data = '0;
  logic          smp_ready;
  logic          fir_wind, fir_load, fir_in_valid;
  logic [DW-1:0] fir_data;
  logic          fir_out_valid = 1'b0;
  logic [DW-1:0] fir_out = '0;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          err;

  always #5 clk = ~clk;

  fir_sequencer #(
    .TAPS     (TAPS),
    .DW       (DW),
    .FIRE_LEN (FIRE_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .coef_valid    (coef_valid),
    .coef_data     (coef_data),
    .coef_ready    (coef_ready),
    .smp_valid     (smp_valid),
    .smp_data      (smp_data),
    .smp_ready     (smp_ready),
    .fir_wind      (fir_wind),
    .fir_load      (fir_load),
    .fir_in_valid  (fir_in_valid),
    .fir_data      (fir_data),
    .fir_out_valid (fir_out_valid),
    .fir_out       (fir_out),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .err           (err)
  );

  typedef struct {
    logic [DW-1:0] smp;
    logic [DW-1:0] exp_res;
  } vec_t;

  vec_t          vec [TAPS];
  int unsigned   n_vec = 0, n_bad = 0;
  logic [DW-1:0] ref_q [$];
  logic [DW-1:0] load_q [$], wind_q [$], mdl_q [$];
  int unsigned   cyc = 0, iv_cnt = 0, iv_bad = 0, run = 0, max_run = 0;
  int unsigned   err_cnt = 0, res_cnt = 0, err_cyc = 0, last_iv_cyc = 0, cd = 0;
  bit            iv_prev = 1'b0, mute = 1'b0;
  logic [DW-1:0] pend = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_sum();
    logic [DW-1:0] s = '0;
    foreach (ref_q[i]) s += ref_q[i];
    return s;
  endfunction

  task automatic ref_clear();
    ref_q.delete();
    for (int i = 0; i < TAPS; i++) ref_q.push_back('0);
  endtask

  // Filter model (out = sum of replayed samples, FIR_LAT cycles after the
  // in_valid rise) and output monitor, both observed on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      mdl_q.delete();
      cd = 0;
      fir_out_valid = 1'b0;
      iv_prev = 1'b0;
    end else begin
      fir_out_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && !mute) begin
          fir_out_valid = 1'b1;
          fir_out = pend;
        end
      end
      if (fir_load) begin
        mdl_q.push_back(fir_data);
        load_q.push_back(fir_data);
      end
      if (fir_in_valid) begin
        iv_cnt++;
        last_iv_cyc = cyc;
        if (fir_data != '0 || fir_load) iv_bad++;
        if (!iv_prev) begin
          pend = '0;
          foreach (mdl_q[i]) pend += mdl_q[i];
          mdl_q.delete();
          cd = FIR_LAT;
        end
      end
      iv_prev = fir_in_valid;
      if (fir_wind) begin
        wind_q.push_back(fir_data);
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (res_valid) res_cnt++;
    end
  end

  task automatic wait_smp_ready();
    @(negedge clk);
    for (int b = 0; b < 300 && !smp_ready; b++) @(negedge clk);
    chk("smp_ready_wait", smp_ready, 1'b1);
  endtask

  task automatic load_coefs(input bit do_start, input bit gaps, input bit all_ones);
    logic [DW-1:0] sent [$];
    if (do_start) begin
      @(negedge clk);
      cfg_start = 1'b1;
      @(posedge clk);
      #1 cfg_start = 1'b0;
    end
    wind_q.delete();
    max_run = 0;
    for (int b = 0; b < 400 && sent.size() < TAPS; b++) begin
      @(negedge clk);
      coef_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      coef_data  = all_ones ? DW'(1) : DW'($urandom);
      if (coef_valid && coef_ready) sent.push_back(coef_data);
    end
    @(negedge clk);
    coef_valid = 1'b0;
    coef_data  = '0;
    @(negedge clk);
    chk("coef_handshakes", sent.size(), TAPS);
    chk("wind_pulses", wind_q.size(), TAPS);
    for (int i = 0; i < TAPS; i++)
      if (i < wind_q.size() && i < sent.size()) chk("wind_data", wind_q[i], sent[i]);
    if (!gaps) chk("wind_consecutive", max_run, TAPS);
    chk("coef_ready_after", coef_ready, 1'b0);
    chk("smp_ready_after", smp_ready, 1'b1);
  endtask

  task automatic send_sample(input logic [DW-1:0] s, output logic [DW-1:0] res);
    bit got = 1'b0;
    wait_smp_ready();
    load_q.delete();
    iv_cnt = 0;
    iv_bad = 0;
    smp_valid = 1'b1;
    smp_data  = s;
    @(posedge clk);
    #1 smp_valid = 1'b0;
    smp_data = '0;
    ref_q.push_front(s);
    void'(ref_q.pop_back());
    @(negedge clk);
    chk("load_start", fir_load, 1'b1);
    res = '0;
    for (int b = 0; b < 200 && !got; b++) begin
      if (res_valid) begin
        got = 1'b1;
        res = res_data;
      end else begin
        @(negedge clk);
      end
    end
    chk("res_seen", got, 1'b1);
    chk("ready_with_res", smp_ready, 1'b1);
    chk("load_count", load_q.size(), TAPS);
    for (int i = 0; i < TAPS; i++)
      if (i < load_q.size()) chk("load_data", load_q[i], ref_q[TAPS-1-i]);
    chk("in_valid_cycles", iv_cnt, FIRE_LEN);
    chk("in_valid_clean", iv_bad, 0);
    @(negedge clk);
    chk("res_one_cycle", res_valid, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got hang, want completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] r;
    logic [DW-1:0] s;
    int unsigned   ec0, rc0;

    for (int i = 0; i < TAPS; i++) begin
      vec[i].smp     = DW'(i + 1);
      vec[i].exp_res = DW'((i + 1) * (i + 2) / 2);
    end
    ref_clear();

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctl", {coef_ready, smp_ready, fir_wind, fir_load, fir_in_valid, res_valid, err}, '0);
    chk("reset_fir_data", fir_data, '0);
    chk("reset_res_data", res_data, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready_low", {coef_ready, smp_ready}, '0);

    // Back-to-back coefficients of 1
    load_coefs(1'b1, 1'b0, 1'b1);

    // Ramp samples 1..16 from the table
    for (int i = 0; i < TAPS; i++) begin
      send_sample(vec[i].smp, r);
      chk("table_res", r, vec[i].exp_res);
    end
    if (load_q.size() == TAPS) begin
      chk("replay_oldest", load_q[0], 16'd1);
      chk("replay_newest", load_q[TAPS-1], 16'd16);
    end

    // Randomized samples, occasional reconfiguration with gaps
    for (int k = 0; k < 20; k++) begin
      if (k % 7 == 3) load_coefs(1'b1, 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      s = DW'($urandom);
      send_sample(s, r);
      chk("rand_res", r, ref_sum());
    end

    // Coefficients with gaps
    load_coefs(1'b1, 1'b1, 1'b0);

    // cfg_start and smp_valid together in READY
    wait_smp_ready();
    cfg_start = 1'b1;
    smp_valid = 1'b1;
    smp_data  = 16'hBEEF;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    smp_valid = 1'b0;
    smp_data  = '0;
    @(negedge clk);
    chk("collide_smp_ready", smp_ready, 1'b0);
    chk("collide_coef_ready", coef_ready, 1'b1);
    chk("collide_no_load", fir_load, 1'b0);
    load_coefs(1'b0, 1'b0, 1'b0);
    send_sample(16'h0042, r);
    chk("post_collide_res", r, ref_sum());

    // Reset during replay
    wait_smp_ready();
    smp_valid = 1'b1;
    smp_data  = 16'h1234;
    @(posedge clk);
    #1 smp_valid = 1'b0;
    smp_data = '0;
    repeat (5) @(negedge clk);
    chk("pre_reset_load", fir_load, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ctl", {coef_ready, smp_ready, fir_wind, fir_load, fir_in_valid, res_valid, err}, '0);
    chk("abort_fir_data", fir_data, '0);
    chk("abort_res_data", res_data, '0);
    @(negedge clk);
    rst = 1'b1;
    ref_clear();
    @(negedge clk);
    chk("abort_idle", smp_ready, 1'b0);
    load_coefs(1'b1, 1'b1, 1'b0);
    send_sample(16'h00AB, r);
    chk("post_reset_res", r, 16'h00AB);

`ifdef FIR_SEQ_TIMEOUT_EN
    // Watchdog: filter never answers
    mute = 1'b1;
    wait_smp_ready();
    ec0 = err_cnt;
    rc0 = res_cnt;
    smp_valid = 1'b1;
    smp_data  = 16'h0777;
    @(posedge clk);
    #1 smp_valid = 1'b0;
    smp_data = '0;
    ref_q.push_front(16'h0777);
    void'(ref_q.pop_back());
    for (int b = 0; b < 200 && err_cnt == ec0; b++) @(negedge clk);
    chk("timeout_err", err_cnt - ec0, 1);
    chk("timeout_delay", err_cyc - last_iv_cyc, TIMEOUT);
    chk("timeout_ready", smp_ready, 1'b1);
    chk("timeout_no_res", res_cnt - rc0, 0);
    @(negedge clk);
    chk("timeout_err_pulse", err, 1'b0);
    mute = 1'b0;
    send_sample(16'h0005, r);
    chk("post_timeout_res", r, ref_sum());
    chk("err_total", err_cnt, 1);
`else
    ec0 = 0;
    rc0 = 0;
    chk("err_total", err_cnt, ec0 + rc0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
